// File: rtl/mux_arb_pkg.sv
// Shared types and the rotating-priority search used by the 4-way mux arbiter.
package mux_arb_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] idx;
    } rr_pick_t;

    // First set bit of req, scanning start, start+1, ... with wrap-around.
    function automatic rr_pick_t next_rr(input logic [N_REQ-1:0] req,
                                         input logic [SEL_W-1:0] start);
        rr_pick_t         r;
        logic [SEL_W-1:0] j;
        r.found = 1'b0;
        r.idx   = start;
        for (int k = 0; k < N_REQ; k++) begin
            j = start + SEL_W'(k);
            if (!r.found && req[j]) begin
                r.found = 1'b1;
                r.idx   = j;
            end
        end
        return r;
    endfunction

    function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        return N_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/mux4a1.sv
// Plain 4:1 single-bit multiplexer; select index is 2*S1+S0.
module mux4a1 (
    input  logic D00,
    input  logic D01,
    input  logic D10,
    input  logic D11,
    input  logic S1,
    input  logic S0,
    output logic Y
);

    always_comb begin
        case ({S1, S0})
            2'b00:   Y = D00;
            2'b01:   Y = D01;
            2'b10:   Y = D10;
            default: Y = D11;
        endcase
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter that owns a mux4a1 and steers one of four data bits to y.
// Optional per-requester grant counters are enabled by defining MUX4_RR_ARB_STATS_EN.
module mux4_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int HOLD_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [3:0]  d,
    output logic [3:0]  gnt,
    output logic [1:0]  sel,
    output logic        y,
    output logic        y_valid,
    output logic        busy
`ifdef MUX4_RR_ARB_STATS_EN
    ,
    output logic [31:0] grant_cnt
`endif
);

    localparam int HCW = 4;
    localparam logic [HCW-1:0] HOLD_LIM = HCW'(HOLD_MAX);

    arb_state_t       state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             vld_q, vld_d;
    logic [HCW-1:0]   hold_q, hold_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;

    rr_pick_t         pick;
    logic [SEL_W-1:0] cur;
    logic [SEL_W-1:0] cur_next;
    logic [N_REQ-1:0] others;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            vld_q   <= 1'b0;
            hold_q  <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            vld_q   <= vld_d;
            hold_q  <= hold_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        sel_d    = sel_q;
        vld_d    = vld_q;
        hold_d   = hold_q;
        ptr_d    = ptr_q;
        pick     = '0;
        cur      = sel_q;
        cur_next = sel_q + SEL_W'(1);
        others   = req & ~onehot(sel_q);

        case (state_q)
            IDLE: begin
                pick = next_rr(req, ptr_q);
                if (pick.found) begin
                    state_d = GRANT;
                    gnt_d   = onehot(pick.idx);
                    sel_d   = pick.idx;
                    vld_d   = 1'b1;
                    hold_d  = HCW'(1);
                end
            end
            GRANT: begin
                if (!req[cur]) begin
                    // Holder released: hand off without an idle cycle if anyone waits.
                    ptr_d = cur_next;
                    pick  = next_rr(req, cur_next);
                    if (pick.found) begin
                        gnt_d  = onehot(pick.idx);
                        sel_d  = pick.idx;
                        hold_d = HCW'(1);
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        vld_d   = 1'b0;
                        hold_d  = '0;
                    end
                end else if (hold_q == HOLD_LIM && others != '0) begin
                    ptr_d  = cur_next;
                    pick   = next_rr(others, cur_next);
                    gnt_d  = onehot(pick.idx);
                    sel_d  = pick.idx;
                    hold_d = HCW'(1);
                end else if (hold_q != HOLD_LIM) begin
                    hold_d = hold_q + HCW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign gnt     = gnt_q;
    assign sel     = sel_q;
    assign y_valid = vld_q;
    assign busy    = (state_q == GRANT);

    mux4a1 u_mux (
        .D00 (d[0]),
        .D01 (d[1]),
        .D10 (d[2]),
        .D11 (d[3]),
        .S1  (sel_q[1]),
        .S0  (sel_q[0]),
        .Y   (y)
    );

`ifdef MUX4_RR_ARB_STATS_EN
    // A new grant is a rising bit of the grant vector, seen one edge early.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cnt
            logic [7:0] cnt_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_q <= '0;
                end else if (gnt_d[gi] && !gnt_q[gi] && cnt_q != 8'hFF) begin
                    cnt_q <= cnt_q + 8'd1;
                end
            end
            assign grant_cnt[gi*8 +: 8] = cnt_q;
        end
    endgenerate
`endif

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed self-checking bench for mux4_rr_arbiter (HOLD_MAX = 4).
`timescale 1ns/1ps
module tb_mux4_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] d;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       y;
    logic       y_valid;
    logic       busy;
`ifdef MUX4_RR_ARB_STATS_EN
    logic [31:0] grant_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    mux4_rr_arbiter #(.HOLD_MAX(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .d         (d),
        .gnt       (gnt),
        .sel       (sel),
        .y         (y),
        .y_valid   (y_valid),
        .busy      (busy)
`ifdef MUX4_RR_ARB_STATS_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [3:0] dv;
        int         g;

        rst = 1'b1;
        req = 4'b0000;
        d   = 4'b0001;
        tick();
        tick();
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_sel", 32'(sel), 32'h0);
        chk("rst_vld", 32'(y_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_y_d0_hi", 32'(y), 32'h1);
        d = 4'b1110;
        #1;
        chk("rst_y_d0_lo", 32'(y), 32'h0);
        rst = 1'b0;
        tick();
        chk("idle_gnt", 32'(gnt), 32'h0);

        // Round robin with all four requesting; each grant lasts HOLD_MAX cycles.
        dv  = 4'b1001;
        d   = dv;
        req = 4'b1111;
        tick();
        for (int k = 0; k < 5; k++) begin
            g = k % 4;
            for (int c = 0; c < 4; c++) begin
                chk($sformatf("rr_gnt_g%0d_c%0d", k, c), 32'(gnt), 32'(4'b0001 << g));
                chk($sformatf("rr_sel_g%0d_c%0d", k, c), 32'(sel), 32'(g));
                chk($sformatf("rr_y_g%0d_c%0d", k, c), 32'(y), 32'(dv[g]));
                chk($sformatf("rr_vld_g%0d_c%0d", k, c), 32'(y_valid), 32'h1);
                tick();
            end
        end
        chk("rr_next_gnt", 32'(gnt), 32'h2);
        req = 4'b0000;
        tick();
        chk("rr_drop_gnt", 32'(gnt), 32'h0);
        chk("rr_drop_busy", 32'(busy), 32'h0);

        // Asynchronous reset in the middle of an active grant.
        req = 4'b0010;
        tick();
        chk("pre_rst_gnt", 32'(gnt), 32'h2);
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_gnt", 32'(gnt), 32'h0);
        chk("midrst_sel", 32'(sel), 32'h0);
        chk("midrst_vld", 32'(y_valid), 32'h0);
        req = 4'b0000;
        tick();
        rst = 1'b0;
        tick();
        tick();
        chk("postrst_gnt", 32'(gnt), 32'h0);
        chk("postrst_busy", 32'(busy), 32'h0);

        // Single requester 2.
        req = 4'b0100;
        d   = 4'b0100;
        tick();
        chk("single_gnt", 32'(gnt), 32'h4);
        chk("single_sel", 32'(sel), 32'h2);
        chk("single_y", 32'(y), 32'h1);
        chk("single_vld", 32'(y_valid), 32'h1);
        chk("single_busy", 32'(busy), 32'h1);
        req = 4'b0000;
        tick();
        chk("single_rel_gnt", 32'(gnt), 32'h0);
        chk("single_rel_vld", 32'(y_valid), 32'h0);
        chk("single_rel_busy", 32'(busy), 32'h0);

        // Sole holder beyond HOLD_MAX, then a competitor appears.
        req = 4'b0001;
        tick();
        for (int c = 0; c < 20; c++) begin
            chk($sformatf("sole_gnt_c%0d", c), 32'(gnt), 32'h1);
            tick();
        end
        chk("sole_hold_sat", 32'(dut.hold_q), 32'h4);
        req = 4'b0101;
        tick();
        chk("sole_move_gnt", 32'(gnt), 32'h4);
        chk("sole_move_sel", 32'(sel), 32'h2);

        // Release with handoff and no idle gap.
        dv  = 4'b1001;
        d   = dv;
        req = 4'b0010;
        tick();
        chk("hand_gnt1", 32'(gnt), 32'h2);
        chk("hand_y1", 32'(y), 32'(dv[1]));
        req = 4'b1000;
        tick();
        chk("hand_gnt3", 32'(gnt), 32'h8);
        chk("hand_sel3", 32'(sel), 32'h3);
        chk("hand_y3", 32'(y), 32'(dv[3]));
        chk("hand_vld3", 32'(y_valid), 32'h1);
        req = 4'b0000;
        tick();
        chk("hand_end_gnt", 32'(gnt), 32'h0);

`ifdef MUX4_RR_ARB_STATS_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("stats_rst", grant_cnt, 32'h0);
        req = 4'b1111;
        tick();
        for (int c = 0; c < 28; c++) tick();
        chk("stats_rr8", grant_cnt, 32'h02020202);
        req = 4'b0000;
        tick();
        for (int c = 0; c < 300; c++) begin
            req = 4'b0001;
            tick();
            req = 4'b0000;
            tick();
        end
        chk("stats_sat", grant_cnt, 32'h020202FF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
